// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// Holds the FSM state type and the bit-select function.
package serializer_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_t;

  // Bit idx of a width-bit word, counted from the end sent first
  function automatic logic next_bit(
    input logic [31:0] word,
    input int unsigned idx,
    input int unsigned width,
    input logic        msb_first
  );
    int unsigned pos;
    pos = msb_first ? (width - 1 - idx) : idx;
    return word[pos[4:0]];
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready,
// one registered bit per clock out, back-to-back with no gap.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sval_q, sval_d;
  logic             done_q, done_d;
  logic             last;
  logic             accept;

  // Handshake: ready when idle or while the last bit is on the wire
  always_comb begin
    last       = (state_q == SHIFT) && (cnt_q == LAST);
    data_ready = !rst && ((state_q == IDLE) || last);
    accept     = data_valid && data_ready;
  end

  // Next-state, counter and registered serial outputs
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sout_d  = IDLE_BIT;
    sval_d  = 1'b0;
    done_d  = 1'b0;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = data_in;
      cnt_d   = '0;
      sout_d  = next_bit(32'(data_in), 32'd0,
                         WIDTH, MSB_FIRST);
      sval_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        SHIFT: begin
          if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            sout_d = next_bit(32'(shreg_q),
                              32'(cnt_q) + 32'd1,
                              WIDTH, MSB_FIRST);
            sval_d = 1'b1;
            done_d = (cnt_q == PENULT);
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sout_q  <= IDLE_BIT;
      sval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      sval_q  <= sval_d;
      done_q  <= done_d;
    end
  end

  assign serial_out   = sout_q;
  assign serial_valid = sval_q;
  assign word_done    = done_q;
  assign busy         = (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: an MSB-first/idle-0 instance
// and an LSB-first/idle-1 instance share the same input stream.
module tb_bit_serializer;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       dready [2];
  logic       sout [2];
  logic       sval [2];
  logic       done [2];
  logic       busy [2];

  exp_t expq [2][$];
  logic model_ready = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   run = 0;
  int   hits = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bit_serializer #(
      .WIDTH    (8),
      .MSB_FIRST(g == 0 ? 1'b1 : 1'b0),
      .IDLE_BIT (g == 1 ? 1'b1 : 1'b0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (dready[g]),
      .serial_out  (sout[g]),
      .serial_valid(sval[g]),
      .word_done   (done[g]),
      .busy        (busy[g])
    );
  end

  task automatic chk(input string nm, input int g,
                     input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%b want=%b",
               nm, g, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d want=%0d",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: an accepted word becomes 8 expected bits
  always @(posedge clk) begin
    if (rst) begin
      expq[0].delete();
      expq[1].delete();
    end else if (data_valid && model_ready) begin
      for (int k = 0; k < 8; k++) begin
        exp_t e;
        e.last = (k == 7);
        e.b = 1'((int'(data_in) >> (7 - k)) & 1);
        expq[0].push_back(e);
        e.b = 1'((int'(data_in) >> k) & 1);
        expq[1].push_back(e);
      end
    end
  end

  // Monitor: compare every output of both instances each cycle
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (expq[g].size() != 0) begin
        chk("data_ready", g, dready[g],
            !rst && expq[g][0].last);
        chk("serial_valid", g, sval[g], 1'b1);
        chk("serial_out", g, sout[g], expq[g][0].b);
        chk("word_done", g, done[g], expq[g][0].last);
        chk("busy", g, busy[g], 1'b1);
        void'(expq[g].pop_front());
      end else begin
        chk("data_ready", g, dready[g], !rst);
        chk("serial_valid", g, sval[g], 1'b0);
        chk("serial_out_idle", g, sout[g], g == 1);
        chk("word_done", g, done[g], 1'b0);
        chk("busy", g, busy[g], 1'b0);
      end
      if (g == 0) model_ready = !rst && expq[0].size() == 0;
    end
    if (sout[0] === 1'b1) begin
      run++;
      if (run == 5) hits++;
    end else begin
      run = 0;
    end
  end

  task automatic send(input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    data_in = w;
    data_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (dready[0]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout word=%h", w);
    end
  endtask

  task automatic idle(input int n);
    data_valid = 1'b0;
    data_in = 8'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int h0;
    rst = 1'b1;
    data_valid = 1'b1;
    data_in = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    send(8'hB5);
    idle(12);

    send(8'hF0);
    send(8'h0F);
    idle(20);

    send(8'h01);
    idle(10);

    send(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    data_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    send(8'h96);
    idle(12);

    h0 = hits;
    send(8'h1F);
    send(8'h00);
    idle(14);
    chk_int("detect_pulses", hits - h0, 1);

    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
      send(8'($urandom));
    end
    idle(14);
    chk_int("drain_dut0", expq[0].size(), 0);
    chk_int("drain_dut1", expq[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
